// File: rtl/snake_pkg.sv
// Shared definitions for the snake body engine: direction codes, FSM states
// and the marker used for segments that are not part of the snake.
package snake_pkg;

  localparam logic [1:0] DIR_LEFT  = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_UP    = 2'b10;
  localparam logic [1:0] DIR_DOWN  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_SCAN,
    ST_COMMIT,
    ST_DEAD
  } state_t;

  // Wide all-ones value; users slice it down to their position width.
  localparam logic [31:0] NO_POS = '1;

  // Left/right and up/down share bit 1 and differ only in bit 0.
  function automatic logic is_opposite(input logic [1:0] a, input logic [1:0] b);
    return (a[1] == b[1]) && (a[0] != b[0]);
  endfunction

endpackage

// File: rtl/snake_next_head.sv
// Combinational next-head calculation: moves the head one cell in the given
// direction and reports whether the move leaves the board.
module snake_next_head #(
  parameter int WIDTH  = 32,
  parameter int HEIGHT = 24,
  parameter int POS_W  = 10,
  parameter int WRAP   = 0
) (
  input  logic [POS_W-1:0] head,
  input  logic [1:0]       dir,
  output logic [POS_W-1:0] cand,
  output logic             wall
);
  import snake_pkg::*;

  int row;
  int col;

  // An edge crossing is only fatal when wrapping is disabled; otherwise the
  // coordinate is folded to the opposite side.
  always_comb begin
    row  = int'(head) / WIDTH;
    col  = int'(head) % WIDTH;
    wall = 1'b0;
    case (dir)
      DIR_LEFT: begin
        if (col == 0) begin
          wall = (WRAP == 0);
          col  = WIDTH - 1;
        end else col = col - 1;
      end
      DIR_RIGHT: begin
        if (col == WIDTH - 1) begin
          wall = (WRAP == 0);
          col  = 0;
        end else col = col + 1;
      end
      DIR_UP: begin
        if (row == 0) begin
          wall = (WRAP == 0);
          row  = HEIGHT - 1;
        end else row = row - 1;
      end
      default: begin
        if (row == HEIGHT - 1) begin
          wall = (WRAP == 0);
          row  = 0;
        end else row = row + 1;
      end
    endcase
    cand = POS_W'(row * WIDTH + col);
  end

endmodule

// File: rtl/snake_body_engine.sv
// Snake body engine: holds the segment list, advances one cell per step,
// grows on food and detects wall/self collision with a one-per-cycle scan.
module snake_body_engine #(
  parameter int WIDTH    = 32,
  parameter int HEIGHT   = 24,
  parameter int MAX_LEN  = 16,
  parameter int POS_W    = 10,
  parameter int LEN_W    = 5,
  parameter int INIT_LEN = 3,
  parameter int WRAP     = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     restart,
  input  logic                     step,
  input  logic [1:0]               dir_req,
  input  logic [POS_W-1:0]         food_pos,
  output logic [MAX_LEN*POS_W-1:0] body,
  output logic [LEN_W-1:0]         len,
  output logic [1:0]               dir,
  output logic                     busy,
  output logic                     done,
  output logic                     ate,
  output logic                     dead
);
  import snake_pkg::*;

  state_t           state_q, state_d;
  logic [POS_W-1:0] seg [MAX_LEN];
  logic [POS_W-1:0] cand_q;
  logic             grow_q;
  logic [LEN_W-1:0] idx_q;
  logic [POS_W-1:0] nh_cand;
  logic             nh_wall;
  logic             calc_grow;
  logic [LEN_W-1:0] calc_limit;
  logic [LEN_W-1:0] scan_limit;
  logic             scan_hit;

  function automatic logic [POS_W-1:0] init_seg(input int i);
    if (i < INIT_LEN) return POS_W'((HEIGHT / 2) * WIDTH + INIT_LEN - 1 - i);
    return NO_POS[POS_W-1:0];
  endfunction

  snake_next_head #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT),
    .POS_W (POS_W),
    .WRAP  (WRAP)
  ) u_next_head (
    .head(seg[0]),
    .dir (dir),
    .cand(nh_cand),
    .wall(nh_wall)
  );

  // A non-growing move vacates the tail, so the tail is excluded from the scan.
  assign calc_grow  = (nh_cand == food_pos);
  assign calc_limit = calc_grow ? len : len - LEN_W'(1);
  assign scan_limit = grow_q ? len : len - LEN_W'(1);
  assign busy       = (state_q == ST_CALC) || (state_q == ST_SCAN) || (state_q == ST_COMMIT);
  assign dead       = (state_q == ST_DEAD);

  always_comb begin
    scan_hit = 1'b0;
    for (int i = 1; i < MAX_LEN; i++)
      if (LEN_W'(i) == idx_q && seg[i] == cand_q) scan_hit = 1'b1;
  end

  always_comb begin
    body = '0;
    for (int i = 0; i < MAX_LEN; i++) body[i*POS_W +: POS_W] = seg[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (step) state_d = ST_CALC;
      ST_CALC: begin
        if (nh_wall)                      state_d = ST_DEAD;
        else if (calc_limit <= LEN_W'(1)) state_d = ST_COMMIT;
        else                              state_d = ST_SCAN;
      end
      ST_SCAN: begin
        if (scan_hit)                                state_d = ST_DEAD;
        else if (idx_q + LEN_W'(1) >= scan_limit)    state_d = ST_COMMIT;
      end
      ST_COMMIT: state_d = ST_IDLE;
      ST_DEAD:   state_d = ST_DEAD;
      default:   state_d = ST_IDLE;
    endcase
    if (restart) state_d = ST_IDLE;
  end

  // Datapath; restart mirrors the asynchronous reset image synchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_LEN; i++) seg[i] <= init_seg(i);
      len    <= LEN_W'(INIT_LEN);
      dir    <= DIR_RIGHT;
      cand_q <= '0;
      grow_q <= 1'b0;
      idx_q  <= '0;
      done   <= 1'b0;
      ate    <= 1'b0;
    end else begin
      done <= 1'b0;
      ate  <= 1'b0;
      if (restart) begin
        for (int i = 0; i < MAX_LEN; i++) seg[i] <= init_seg(i);
        len    <= LEN_W'(INIT_LEN);
        dir    <= DIR_RIGHT;
        grow_q <= 1'b0;
        idx_q  <= '0;
      end else begin
        case (state_q)
          ST_IDLE: if (step && !is_opposite(dir_req, dir)) dir <= dir_req;
          ST_CALC: begin
            cand_q <= nh_cand;
            grow_q <= calc_grow;
            idx_q  <= LEN_W'(1);
          end
          ST_SCAN: idx_q <= idx_q + LEN_W'(1);
          ST_COMMIT: begin
            for (int i = 1; i < MAX_LEN; i++)
              if (LEN_W'(i) < len || (grow_q && LEN_W'(i) == len)) seg[i] <= seg[i-1];
            seg[0] <= cand_q;
            if (grow_q && len < LEN_W'(MAX_LEN)) len <= len + LEN_W'(1);
            done <= 1'b1;
            ate  <= grow_q;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
